// File: rtl/ex_muldiv.sv
// EX/MEM pipeline register with an iterative RV32M multiply/divide unit.
// M-extension ops stall the front end and push bubbles into MEM until done.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_vld,
  input  logic [31:0]     i_inst,
  input  logic [4:0]      i_rs1_raddr,
  input  logic [4:0]      i_rs2_raddr,
  input  logic [XLEN-1:0] i_rs1_rdata,
  input  logic [XLEN-1:0] i_rs2_rdata,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_nxt_pc,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic            i_md_en,
  input  logic [2:0]      i_md_op,
  input  logic [2:0]      i_opsel,
  input  logic            i_mem_reg,
  input  logic [4:0]      i_rd_waddr,
  input  logic            i_rd_wen,
  output logic            o_stall,
  output logic            o_vld,
  output logic [31:0]     o_inst,
  output logic [4:0]      o_rs1_raddr,
  output logic [4:0]      o_rs2_raddr,
  output logic [XLEN-1:0] o_rs1_rdata,
  output logic [XLEN-1:0] o_rs2_rdata,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_nxt_pc,
  output logic [2:0]      o_opsel,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic            o_mem_reg,
  output logic [XLEN-1:0] o_res,
  output logic [4:0]      o_rd_waddr,
  output logic            o_rd_wen
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_nxt;
  logic            stall;
  logic [XLEN-1:0] res_nxt;

  logic [2:0]      op_q;
  logic [XLEN-1:0] mul_a, mul_b;
  logic [XLEN-1:0] quo, rem, dvs;
  logic            neg_q, neg_r;
  logic [4:0]      cnt;

  logic            md_start, is_div, signed_div, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  assign md_start   = i_vld & i_md_en;
  assign is_div     = i_md_op[2];
  assign signed_div = ~i_md_op[0];
  assign div_zero   = (i_rs2_rdata == '0);
  assign div_ovf    = signed_div && (i_rs1_rdata == 32'h8000_0000) && (i_rs2_rdata == 32'hFFFF_FFFF);
  assign abs_a      = (signed_div & i_rs1_rdata[XLEN-1]) ? -i_rs1_rdata : i_rs1_rdata;
  assign abs_b      = (signed_div & i_rs2_rdata[XLEN-1]) ? -i_rs2_rdata : i_rs2_rdata;

  // A 64-bit product of sign/zero-extended operands is exact modulo 2^64
  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] mul_a64, mul_b64, prod;
  logic [XLEN-1:0] mul_res;

  assign a_sgn   = (op_q == 3'b001) || (op_q == 3'b010);
  assign b_sgn   = (op_q == 3'b001);
  assign mul_a64 = {{XLEN{a_sgn & mul_a[XLEN-1]}}, mul_a};
  assign mul_b64 = {{XLEN{b_sgn & mul_b[XLEN-1]}}, mul_b};
  assign prod    = mul_a64 * mul_b64;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] q_fix, r_fix, div_res;

  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem : rem;
  assign div_res = op_q[1] ? r_fix : q_fix;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    res_nxt   = i_alu_res;
    case (state)
      IDLE: begin
        if (md_start) begin
          stall = 1'b1;
          if (!is_div)                state_nxt = MUL;
          else if (div_zero | div_ovf) state_nxt = DONE;
          else                        state_nxt = DIV;
        end
      end
      MUL: begin
        res_nxt   = mul_res;
        state_nxt = IDLE;
      end
      DIV: begin
        stall = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        res_nxt   = div_res;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_stall = stall & i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Special-case divides preload the final quotient/remainder and skip DIV
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q  <= '0;
      mul_a <= '0;
      mul_b <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            op_q  <= i_md_op;
            mul_a <= i_rs1_rdata;
            mul_b <= i_rs2_rdata;
            dvs   <= abs_b;
            cnt   <= '0;
            if (div_zero) begin
              quo   <= '1;
              rem   <= i_rs1_rdata;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (div_ovf) begin
              quo   <= 32'h8000_0000;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo   <= abs_a;
              rem   <= '0;
              neg_q <= signed_div & (i_rs1_rdata[XLEN-1] ^ i_rs2_rdata[XLEN-1]);
              neg_r <= signed_div & i_rs1_rdata[XLEN-1];
            end
          end
        end
        DIV: begin
          cnt <= cnt + 5'd1;
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Stall cycles still load the data fields but can never write or validate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld        <= 1'b0;
      o_inst       <= '0;
      o_rs1_raddr  <= '0;
      o_rs2_raddr  <= '0;
      o_rs1_rdata  <= '0;
      o_rs2_rdata  <= '0;
      o_pc         <= '0;
      o_nxt_pc     <= '0;
      o_opsel      <= '0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_mem_reg    <= 1'b0;
      o_res        <= '0;
      o_rd_waddr   <= '0;
      o_rd_wen     <= 1'b0;
    end else begin
      o_vld        <= i_vld & ~stall;
      o_inst       <= i_inst;
      o_rs1_raddr  <= i_rs1_raddr;
      o_rs2_raddr  <= i_rs2_raddr;
      o_rs1_rdata  <= i_rs1_rdata;
      o_rs2_rdata  <= i_rs2_rdata;
      o_pc         <= i_pc;
      o_nxt_pc     <= i_nxt_pc;
      o_opsel      <= i_opsel;
      o_dmem_addr  <= i_alu_res;
      o_dmem_wdata <= i_rs2_rdata;
      o_mem_reg    <= i_mem_reg & ~stall;
      o_res        <= res_nxt;
      o_rd_waddr   <= i_rd_waddr;
      o_rd_wen     <= i_rd_wen & ~stall;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: ALU passthrough, MUL/DIV family,
// special-case divides, bubble behaviour and reset during a divide.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_vld;
  logic [31:0] i_inst;
  logic [4:0]  i_rs1_raddr, i_rs2_raddr;
  logic [31:0] i_rs1_rdata, i_rs2_rdata, i_pc, i_nxt_pc, i_alu_res;
  logic        i_md_en;
  logic [2:0]  i_md_op, i_opsel;
  logic        i_mem_reg;
  logic [4:0]  i_rd_waddr;
  logic        i_rd_wen;
  logic        o_stall, o_vld;
  logic [31:0] o_inst;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr;
  logic [31:0] o_rs1_rdata, o_rs2_rdata, o_pc, o_nxt_pc;
  logic [2:0]  o_opsel;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic        o_mem_reg;
  logic [31:0] o_res;
  logic [4:0]  o_rd_waddr;
  logic        o_rd_wen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .i_inst(i_inst),
    .i_rs1_raddr(i_rs1_raddr), .i_rs2_raddr(i_rs2_raddr),
    .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
    .i_pc(i_pc), .i_nxt_pc(i_nxt_pc), .i_alu_res(i_alu_res),
    .i_md_en(i_md_en), .i_md_op(i_md_op), .i_opsel(i_opsel),
    .i_mem_reg(i_mem_reg), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
    .o_stall(o_stall), .o_vld(o_vld), .o_inst(o_inst),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
    .o_rs1_rdata(o_rs1_rdata), .o_rs2_rdata(o_rs2_rdata),
    .o_pc(o_pc), .o_nxt_pc(o_nxt_pc), .o_opsel(o_opsel),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_mem_reg(o_mem_reg), .o_res(o_res), .o_rd_waddr(o_rd_waddr),
    .o_rd_wen(o_rd_wen)
  );

  typedef struct {
    logic        md_en;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic md_en, input logic [2:0] op,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] alu, input logic [4:0] rd);
    i_vld       = 1'b1;
    i_md_en     = md_en;
    i_md_op     = op;
    i_rs1_rdata = rs1;
    i_rs2_rdata = rs2;
    i_alu_res   = alu;
    i_rd_waddr  = rd;
    i_rd_wen    = 1'b1;
    i_mem_reg   = 1'b0;
    i_opsel     = 3'b010;
    i_inst      = 32'h0000_0033;
    i_rs1_raddr = 5'd1;
    i_rs2_raddr = 5'd2;
    i_pc        = 32'h0000_1000;
    i_nxt_pc    = 32'h0000_1004;
    #1;
  endtask

  // Counts edges until o_vld rises (bounded), stall cycles seen, and any write leaking from a bubble
  task automatic run_op(output int edges, output int stalls, output logic bubble_bad);
    edges      = 0;
    stalls     = 0;
    bubble_bad = 1'b0;
    while (edges < 40) begin
      if (o_stall) stalls++;
      @(posedge clk);
      #1;
      edges++;
      if (o_vld) break;
      if (o_rd_wen || o_mem_reg) bubble_bad = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          edges, stalls;
    logic        bbad;

    vecs[0]  = '{1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_1234, 5'd5,  32'h0000_1234, 1};
    vecs[1]  = '{1'b1, 3'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0100, 5'd6,  32'hFFFF_FFFF, 2};
    vecs[2]  = '{1'b1, 3'd0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0104, 5'd7,  32'h0000_0000, 2};
    vecs[3]  = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0108, 5'd8,  32'hFFFF_FFFE, 2};
    vecs[4]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_010C, 5'd9,  32'hFFFF_FFFF, 2};
    vecs[5]  = '{1'b1, 3'd0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0110, 5'd10, 32'h2345_6780, 2};
    vecs[6]  = '{1'b1, 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0114, 5'd11, 32'hFFFF_FFFD, 34};
    vecs[7]  = '{1'b1, 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0118, 5'd12, 32'hFFFF_FFFF, 34};
    vecs[8]  = '{1'b1, 3'd5, 32'd100,       32'd7,         32'h0000_011C, 5'd13, 32'd14,        34};
    vecs[9]  = '{1'b1, 3'd7, 32'd100,       32'd7,         32'h0000_0120, 5'd14, 32'd2,         34};
    vecs[10] = '{1'b1, 3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0124, 5'd15, 32'd1,         34};
    vecs[11] = '{1'b1, 3'd5, 32'h0000_0055, 32'h0000_0000, 32'h0000_0128, 5'd16, 32'hFFFF_FFFF, 2};
    vecs[12] = '{1'b1, 3'd7, 32'h0000_0055, 32'h0000_0000, 32'h0000_012C, 5'd17, 32'h0000_0055, 2};
    vecs[13] = '{1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0130, 5'd18, 32'h0000_0000, 2};
    vecs[14] = '{1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0134, 5'd19, 32'h8000_0000, 2};
    vecs[15] = '{1'b1, 3'd4, 32'h8000_0000, 32'h0000_0001, 32'h0000_0138, 5'd20, 32'h8000_0000, 34};
    vecs[16] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_013C, 5'd21, 32'h0FFF_FFFF, 34};

    i_rst_n = 1'b0;
    apply_stimulus(1'b0, 3'd0, '0, '0, '0, 5'd0);
    i_vld    = 1'b0;
    i_rd_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_vld",   {31'b0, o_vld},    32'd0);
    check_output("reset_wen",   {31'b0, o_rd_wen}, 32'd0);
    check_output("reset_res",   o_res,             32'd0);
    check_output("reset_addr",  o_dmem_addr,       32'd0);
    check_output("reset_stall", {31'b0, o_stall},  32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i].md_en, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].alu, vecs[i].rd);
      run_op(edges, stalls, bbad);
      check_output($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].exp_lat));
      check_output($sformatf("v%0d_stalls", i),  32'(stalls), 32'(vecs[i].exp_lat - 1));
      check_output($sformatf("v%0d_bubble", i),  {31'b0, bbad}, 32'd0);
      check_output($sformatf("v%0d_res", i),     o_res, vecs[i].exp_res);
      check_output($sformatf("v%0d_rd", i),      {27'b0, o_rd_waddr}, {27'b0, vecs[i].rd});
      check_output($sformatf("v%0d_addr", i),    o_dmem_addr, vecs[i].alu);
      check_output($sformatf("v%0d_wen", i),     {31'b0, o_rd_wen}, 32'd1);
    end

    // M op with no valid instruction must be ignored
    i_vld   = 1'b0;
    i_md_en = 1'b1;
    i_md_op = 3'd4;
    #1;
    check_output("ignored_stall", {31'b0, o_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("ignored_vld", {31'b0, o_vld}, 32'd0);

    // Load waiting behind a divide issues intact once the divide completes
    apply_stimulus(1'b1, 3'd5, 32'd100, 32'd7, 32'h0000_0077, 5'd3);
    run_op(edges, stalls, bbad);
    check_output("ldq_div_res",    o_res, 32'd14);
    check_output("ldq_bubble",     {31'b0, bbad}, 32'd0);
    check_output("ldq_stalls",     32'(stalls), 32'd33);
    i_md_en     = 1'b0;
    i_mem_reg   = 1'b1;
    i_opsel     = 3'b100;
    i_alu_res   = 32'h0000_2000;
    i_rs2_rdata = 32'h0000_DEAD;
    i_rd_waddr  = 5'd9;
    #1;
    check_output("ldq_no_stall", {31'b0, o_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("ld_vld",   {31'b0, o_vld},     32'd1);
    check_output("ld_memrg", {31'b0, o_mem_reg}, 32'd1);
    check_output("ld_addr",  o_dmem_addr,        32'h0000_2000);
    check_output("ld_opsel", {29'b0, o_opsel},   32'd4);
    check_output("ld_rd",    {27'b0, o_rd_waddr}, 32'd9);
    check_output("ld_wdata", o_dmem_wdata,       32'h0000_DEAD);

    // Reset at divide iteration 10 aborts the op
    apply_stimulus(1'b1, 3'd4, 32'd1000, 32'd3, 32'h0000_0ABC, 5'd7);
    repeat (11) @(posedge clk);
    #1;
    check_output("mid_div_stall", {31'b0, o_stall}, 32'd1);
    check_output("mid_div_addr",  o_dmem_addr,      32'h0000_0ABC);
    i_rst_n = 1'b0;
    #1;
    check_output("rst_stall", {31'b0, o_stall},    32'd0);
    check_output("rst_vld",   {31'b0, o_vld},      32'd0);
    check_output("rst_addr",  o_dmem_addr,         32'd0);
    check_output("rst_rd",    {27'b0, o_rd_waddr}, 32'd0);
    check_output("rst_res",   o_res,               32'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    apply_stimulus(1'b0, 3'd0, 32'd0, 32'd0, 32'h0000_55AA, 5'd4);
    check_output("post_rst_stall", {31'b0, o_stall}, 32'd0);
    run_op(edges, stalls, bbad);
    check_output("post_rst_lat", 32'(edges), 32'd1);
    check_output("post_rst_res", o_res, 32'h0000_55AA);
    i_vld = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute-stage back end with the EX/MEM pipeline register; sits directly upstream of the memory stage and drives its i_* inputs.
- ALU results are computed combinationally upstream and arrive on i_alu_res; this block adds an iterative RV32M multiply/divide unit.
- While an M-extension op is in flight, the block stalls the front end and inserts bubbles into MEM.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_vld  in  1  instruction in EX is valid
- i_inst  in  32  instruction word, passthrough
- i_rs1_raddr, i_rs2_raddr  in  5 each  passthrough
- i_rs1_rdata, i_rs2_rdata  in  32 each  operands; rs2 is also store data
- i_pc, i_nxt_pc  in  32 each  passthrough
- i_alu_res  in  32  ALU result; also the load/store address
- i_md_en  in  1  instruction is an M-extension op
- i_md_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_opsel  in  3  memory access size/sign, passthrough
- i_mem_reg  in  1  writeback selects load data
- i_rd_waddr  in  5  destination register
- i_rd_wen  in  1  destination write enable
- o_stall  out  1  front end must hold EX inputs stable
- o_vld, o_inst, o_rs1_raddr, o_rs2_raddr, o_rs1_rdata, o_rs2_rdata, o_pc, o_nxt_pc  out  EX/MEM copies
- o_opsel  out  3  EX/MEM copy
- o_dmem_addr  out  32  registered i_alu_res
- o_dmem_wdata  out  32  registered i_rs2_rdata
- o_mem_reg  out  1  EX/MEM copy
- o_res  out  32  registered result: ALU result or M-unit result
- o_rd_waddr  out  5  EX/MEM copy
- o_rd_wen  out  1  EX/MEM copy

Behaviour:
- Reset (async, on i_rst_n low): every output register clears to 0 and the FSM goes to IDLE. o_stall = 0 while in reset.
- Non-M op (i_vld & ~i_md_en, FSM in IDLE):
  - EX/MEM captures all fields on the next edge; 1-cycle latency.
  - o_res = i_alu_res.
- Invalid input (i_vld = 0): captured as-is, so o_vld = 0 follows.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on i_vld & i_md_en:
  - o_stall = 1 combinationally.
  - Latch operands and op.
  - MUL family -> MUL.
  - DIV/REM family with divisor 0, or signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM) -> DONE with special result.
  - Other DIV/REM -> DIV; clear iteration counter.
- MUL (1 cycle):
  - 64-bit product of latched operands; signedness per op.
  - MUL returns the low word; the others return the high word.
  - o_stall = 0. EX/MEM captures the result on the edge. Next state IDLE.
- DIV: 32 iterations of radix-2 restoring division on operand magnitudes, one per cycle, o_stall = 1. Counter 0..31; after iteration 31 -> DONE.
- DONE:
  - Sign fix: quotient negated if operand signs differ (signed ops); remainder takes the dividend's sign.
  - o_stall = 0. EX/MEM captures the result. Next state IDLE.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow: quotient 0x80000000, remainder 0.
- Bubble rule: every cycle o_stall = 1, EX/MEM loads a bubble (o_vld = 0, o_rd_wen = 0, o_mem_reg = 0). Data fields are don't-care but must not write.
- Input sourcing during stall: upstream holds all i_* stable, so on the completing edge passthrough fields come from the live inputs.
- Latency from inputs presented to o_vld high:
  - ALU op: 1 edge.
  - MUL family: 2 edges.
  - Special-case divide: 2 edges.
  - Normal divide: 34 edges.
- Back-to-back M ops: the next M op is accepted in IDLE the cycle after completion; no extra bubble beyond its own latency.
- Reset mid-operation aborts the op. The FSM returns to IDLE with no output pulse, and o_stall drops immediately.
- i_md_en with i_vld = 0 is ignored.

Test Plan:
- ALU op: i_alu_res = 0x1234, rd = 5, wen = 1 -> next edge o_vld = 1, o_res = 0x1234, o_rd_waddr = 5, o_dmem_addr = 0x1234.
- MULH: rs1 = 0x80000000, rs2 = 2 -> o_stall high for 1 cycle, one bubble, then o_res = 0xFFFFFFFF. MUL of the same operands -> o_res = 0x00000000.
- DIV: rs1 = 0xFFFFFFF9 (-7), rs2 = 2 -> 33 stall cycles, then o_res = 0xFFFFFFFD. REM of the same operands -> o_res = 0xFFFFFFFF. DIVU 100/7 -> 14.
- Special cases: DIVU x/0 -> 0xFFFFFFFF; REM 0x80000000 % 0xFFFFFFFF -> 0, 2-edge latency, no DIV state entered.
- Stall bubbles: a load queued behind DIV -> MEM sees o_vld = 0 and o_rd_wen = 0 for every stall cycle. The load then issues with its o_dmem_addr/o_opsel intact.
- Reset: assert i_rst_n = 0 at DIV iteration 10 -> all outputs 0 asynchronously. After release, o_stall = 0 and the next ALU op completes in 1 edge.
